// File: rtl/set_loader_pkg.sv
// set_loader_pkg: shared job type, frame length and issue-state encoding for the SET feeder.
package set_loader_pkg;
  localparam int NIB_PER_JOB = 10;
  typedef struct packed {
    logic [1:0]  mode;
    logic [23:0] central;
    logic [11:0] radius;
  } set_job_t;
  typedef enum logic {S_IDLE, S_WAIT} issue_state_t;
endpackage

// File: rtl/set_job_fifo.sv
// set_job_fifo: power-of-two job FIFO with first-word-fall-through head.
module set_job_fifo
  import set_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  set_job_t din,
  output set_job_t head,
  output logic [AW:0] cnt
);
  logic [AW-1:0] wp, rp;
  set_job_t mem [DEPTH];
  assign head = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/set_pattern_loader.sv
// set_pattern_loader: assembles nibble frames into SET jobs, buffers them and issues one per en pulse.
module set_pattern_loader
  import set_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    nib_in,
  input  logic          nib_valid,
  input  logic          frame_start,
  output logic          nib_ready,
  input  logic          busy,
  input  logic          valid,
  output logic          en,
  output logic [23:0]   central,
  output logic [11:0]   radius,
  output logic [1:0]    mode,
  output logic [CW-1:0] fifo_cnt,
  output logic [7:0]    jobs_done,
  output logic          frame_err
);
  logic [3:0] nib_idx;
  logic [1:0] asm_mode;
  logic [31:0] asm_sh;
  logic acc, push, pop;
  set_job_t push_job, head;
  issue_state_t state, nxt;
  assign nib_ready = !rst && (fifo_cnt < CW'(DEPTH));
  assign acc = nib_valid && nib_ready;
  assign push = acc && !frame_start && nib_idx == 4'(NIB_PER_JOB - 1);
  // n1..n8 sit in the shift register; n9 joins them straight from the port on the push edge
  assign push_job = '{mode: asm_mode, central: asm_sh[31:8], radius: {asm_sh[7:0], nib_in}};
  assign pop = state == S_IDLE && fifo_cnt != '0 && !busy;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      nib_idx   <= '0;
      frame_err <= 1'b0;
      asm_mode  <= '0;
      asm_sh    <= '0;
    end else if (acc) begin
      if (frame_start) begin
        frame_err <= frame_err | (nib_idx != '0);
        asm_mode  <= nib_in[1:0];
        nib_idx   <= 4'd1;
      end else if (nib_idx == '0) begin
        frame_err <= 1'b1;
      end else begin
        asm_sh  <= {asm_sh[27:0], nib_in};
        nib_idx <= push ? 4'd0 : nib_idx + 4'd1;
      end
    end
  set_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(push_job), .head(head), .cnt(fifo_cnt)
  );
  always_comb nxt = pop ? S_WAIT : (state == S_WAIT && valid) ? S_IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= S_IDLE;
      en        <= 1'b0;
      central   <= '0;
      radius    <= '0;
      mode      <= '0;
      jobs_done <= '0;
    end else begin
      state <= nxt;
      en    <= pop;
      if (pop) {mode, central, radius} <= head;
      if (state == S_WAIT && valid) jobs_done <= jobs_done + 8'd1;
    end
endmodule
